mem_port_arbiter: RTL

//  Shares one single-port instruction/data memory bus between the IF-stage fetch and
//  the MEM-stage load/store (m_mem_read/m_mem_write from control). Sequences bus

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and MEM-stage load/store.
// It sequences bus accesses, holds returned data until the pipeline advances, and drives pipe_stall.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                bxx_flush,
  input  logic                m_mem_read,
  input  logic                m_mem_write,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_ready,
  output logic                pipe_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEM_ACC = 2'd1;
  localparam logic [1:0] IF_ACC  = 2'd2;
  localparam logic [1:0] IF_DROP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic              m_ready_q, m_ready_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic mem_need, if_need, timeout;

  assign mem_need   = (m_mem_read | m_mem_write) & ~m_ready_q;
  assign if_need    = if_req & ~if_ready_q & ~bxx_flush;
  assign pipe_stall = mem_need | if_need;
  // Abort once the access has spent MAX_WAIT cycles on the bus without an ack.
  assign timeout    = (wait_q == CNT_W'(MAX_WAIT - 1)) & ~bus_ack;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = if_ready_q;
    m_rdata_d   = m_rdata_q;
    m_ready_d   = m_ready_q;
    err_d       = err_q;
    wait_d      = '0;

    // Served flags drop when the pipeline advances; a flush also kills a held fetch.
    if (!pipe_stall) begin
      m_ready_d  = 1'b0;
      if_ready_d = 1'b0;
    end
    if (bxx_flush) begin
      if_ready_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (mem_need) begin
          state_d     = MEM_ACC;
          bus_req_d   = 1'b1;
          bus_we_d    = m_mem_write;
          bus_addr_d  = m_addr;
          bus_wdata_d = m_mem_write ? m_wdata : '0;
          bus_wstrb_d = m_mem_write ? m_wstrb : '0;
        end else if (if_need) begin
          state_d     = IF_ACC;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end
      end
      MEM_ACC: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          m_ready_d = 1'b1;
          if (!bus_we_q) begin
            m_rdata_d = bus_rdata;
          end
        end else if (timeout) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          m_ready_d = 1'b1;
          m_rdata_d = '0;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      IF_ACC: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!bxx_flush) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus_rdata;
          end
        end else if (timeout) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          if (!bxx_flush) begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end
        end else if (bxx_flush) begin
          // Bus request stays up; the eventual ack is swallowed in IF_DROP.
          state_d = IF_DROP;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      IF_DROP: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end else if (timeout) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      m_rdata_q   <= '0;
      m_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      m_rdata_q   <= m_rdata_d;
      m_ready_q   <= m_ready_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign m_rdata   = m_rdata_q;
  assign m_ready   = m_ready_q;
  assign bus_err   = err_q;

endmodule
